// File: rtl/blackjack_pkg.sv
// ---------------------------------------------------------------------------
// blackjack_pkg
// Shared definitions for the blackjack card shoe:
//   - rank constants (ACE, KING) and the number of ranks in a deck
//   - LFSR feedback tap mask for the 8-bit x^8+x^6+x^5+x^4+1 polynomial
//   - shoe controller state enum
//   - rank_to_value : rank 1..13 -> blackjack value 1..10
//   - hilo_weight   : rank 1..13 -> Hi-Lo card-counting weight (+1/0/-1)
// ---------------------------------------------------------------------------
package blackjack_pkg;

  localparam int unsigned ACE       = 1;
  localparam int unsigned KING      = 13;
  localparam int          NUM_RANKS = 13;

  // Bits 7,5,4,3 of the shift register feed the XOR (x^8, x^6, x^5, x^4).
  localparam logic [7:0] LFSR8_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    IDLE,
    SHUFFLE,
    PICK,
    SCAN,
    DELIVER
  } shoe_state_e;

  // Face cards count as 10; the Ace is delivered as 1.
  function automatic logic [4:0] rank_to_value(input logic [3:0] rank);
    return (rank >= 4'd10) ? 5'd10 : {1'b0, rank};
  endfunction

  // Low cards 2..6 are +1, 7..9 are neutral, tens and Aces are -1.
  function automatic logic signed [1:0] hilo_weight(input logic [3:0] rank);
    if (rank == 4'(ACE) || rank >= 4'd10) begin
      return -2'sd1;
    end else if (rank <= 4'd6) begin
      return 2'sd1;
    end else begin
      return 2'sd0;
    end
  endfunction

endpackage

// File: rtl/shoe_lfsr.sv
// ---------------------------------------------------------------------------
// shoe_lfsr
// Free-running Fibonacci LFSR used to pick a starting rank for each draw.
// The seed is loaded while reset is high; an all-zero seed would lock the
// register up, so it is replaced by 1.
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high; loads the seed
//   seed       W-bit seed value
//   pick_bits  low nibble of the shift register, consumed by the rank picker
// ---------------------------------------------------------------------------
module shoe_lfsr #(
  parameter int              W    = 8,
  parameter logic [W-1:0]    TAPS = W'(blackjack_pkg::LFSR8_TAPS)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] seed,
  output logic [3:0]   pick_bits
);

  logic [W-1:0] lfsr;
  logic         feedback;

  assign feedback  = ^(lfsr & TAPS);
  assign pick_bits = lfsr[3:0];

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= (seed == '0) ? W'(1) : seed;
    end else begin
      lfsr <= {lfsr[W-2:0], feedback};
    end
  end

endmodule

// File: rtl/blackjack_shoe.sv
// ---------------------------------------------------------------------------
// blackjack_shoe
// Finite shoe of NUM_DECKS decks kept as 13 per-rank counters. Each draw
// picks a pseudo-random rank, walks forward to the next rank that still has
// cards, delivers it and removes it from the shoe. An empty shoe refills
// itself automatically before serving a draw.
// Parameters:
//   NUM_DECKS  decks in the shoe (1..4)
//   LFSR_W     width of the rank-selection LFSR (>= 4)
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high
//   seed         LFSR seed, loaded at reset (0 is replaced by 1)
//   draw_req     level request for one card, taken when ready=1
//   shuffle_req  refill the shoe, taken only when ready=1
//   ready        shoe idle and able to accept a request
//   card_valid   one-cycle strobe qualifying card_out/card_rank
//   card_out     blackjack value 1..10 (Ace=1, J/Q/K=10), held until next card
//   card_rank    rank 1..13, held until next card
//   cards_left   cards remaining in the shoe
//   reshuffled   one-cycle pulse after a refill completes
//   running_count  (only with SHOE_HILO_COUNT_EN) signed Hi-Lo running count
// Build option: define SHOE_HILO_COUNT_EN to add the running_count output.
// ---------------------------------------------------------------------------
module blackjack_shoe
  import blackjack_pkg::*;
#(
  parameter int NUM_DECKS = 1,
  parameter int LFSR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] seed,
  input  logic              draw_req,
  input  logic              shuffle_req,
  output logic              ready,
  output logic              card_valid,
  output logic [4:0]        card_out,
  output logic [3:0]        card_rank,
  output logic [7:0]        cards_left,
  output logic              reshuffled
`ifdef SHOE_HILO_COUNT_EN
  ,
  output logic signed [7:0] running_count
`endif
);

  localparam logic [4:0] RANK_FULL = 5'(4 * NUM_DECKS);
  localparam logic [7:0] SHOE_FULL = 8'(52 * NUM_DECKS);

  shoe_state_e state, state_next;
  logic [4:0]  count [NUM_RANKS];
  logic [3:0]  rank_idx;
  logic        draw_pending;
  logic [3:0]  pick_bits;
  logic [3:0]  pick_idx;
  logic        rank_empty;

  shoe_lfsr #(
    .W (LFSR_W)
  ) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .seed      (seed),
    .pick_bits (pick_bits)
  );

  // Fold the 4-bit random value 0..15 onto rank indices 0..12.
  assign pick_idx   = (pick_bits >= 4'(KING)) ? pick_bits - 4'(KING) : pick_bits;
  assign rank_empty = (count[rank_idx] == '0);

  assign ready      = (state == IDLE);
  assign card_valid = (state == DELIVER);

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic
  // -------------------------------------------------------------------------
  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (shuffle_req) begin
          state_next = SHUFFLE;
        end else if (draw_req) begin
          state_next = (cards_left == '0) ? SHUFFLE : PICK;
        end
      end
      SHUFFLE: state_next = draw_pending ? PICK : IDLE;
      PICK:    state_next = SCAN;
      SCAN:    state_next = rank_empty ? SCAN : DELIVER;
      DELIVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Shoe contents, rank selection and card output registers
  // -------------------------------------------------------------------------
  // NOTE: the rank counters are the shoe itself, so they are reset to a full
  // shoe like any other control state rather than left uninitialised.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_RANKS; i++) begin
        count[i] <= RANK_FULL;
      end
      cards_left   <= SHOE_FULL;
      rank_idx     <= '0;
      draw_pending <= 1'b0;
      card_rank    <= '0;
      card_out     <= '0;
      reshuffled   <= 1'b0;
    end else begin
      reshuffled <= (state == SHUFFLE);
      case (state)
        IDLE: begin
          // Remember a draw that has to wait for an automatic refill.
          draw_pending <= !shuffle_req && draw_req && (cards_left == '0);
        end
        SHUFFLE: begin
          for (int i = 0; i < NUM_RANKS; i++) begin
            count[i] <= RANK_FULL;
          end
          cards_left   <= SHOE_FULL;
          draw_pending <= 1'b0;
        end
        PICK: begin
          rank_idx <= pick_idx;
        end
        SCAN: begin
          if (rank_empty) begin
            rank_idx <= (rank_idx == 4'(KING - 1)) ? 4'd0 : rank_idx + 4'd1;
          end else begin
            // Register the card on the way into DELIVER so it is stable for
            // the whole strobe cycle and holds afterwards.
            card_rank <= rank_idx + 4'd1;
            card_out  <= rank_to_value(rank_idx + 4'd1);
          end
        end
        DELIVER: begin
          if (!rank_empty) begin
            count[rank_idx] <= count[rank_idx] - 5'd1;
            cards_left      <= cards_left - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHOE_HILO_COUNT_EN
  // -------------------------------------------------------------------------
  // Hi-Lo running count over the cards dealt since the last refill
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running_count <= '0;
    end else if (state == SHUFFLE) begin
      running_count <= '0;
    end else if (state == DELIVER) begin
      running_count <= running_count + 8'(hilo_weight(card_rank));
    end
  end
`endif

endmodule
